ecc_57_rd_err_mon: RTL and testbench

- Read-side stage directly downstream of the 57-bit/7-parity SECDED decode core in the ECC FIFO path.
- Accepts corrected data words with their sbit/dbit flags and registers them through a 2-entry skid buffer with valid/ready flow control.
- Maintains saturating error counters, sticky status, first-error capture and an error interrupt pulse for the FIFO status registers.

---
 rtl/ecc_57_rd_err_mon_if.sv | 31 +++
 rtl/ecc_57_rd_err_mon.sv | 152 +++++++++++++++
 tb/tb_ecc_57_rd_err_mon.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ecc_57_rd_err_mon_if.sv
// ecc_57_rd_err_mon_if
//   Stream bundle for the ECC read-side error monitor: the decoder-facing
//   input handshake (in_*) and the consumer-facing output handshake (out_*).
//   slave  : the monitor stage (accepts in_*, drives out_*)
//   master : the environment (drives in_* and out_ready)
interface ecc_57_rd_err_mon_if #(
  parameter int unsigned DATA_WIDTH = 57,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  in_sbit_err;
  logic                  in_dbit_err;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sbit_err;
  logic                  out_dbit_err;

  modport slave (
    input  in_valid, in_data, in_addr, in_sbit_err, in_dbit_err, out_ready,
    output in_ready, out_valid, out_data, out_sbit_err, out_dbit_err
  );

  modport master (
    output in_valid, in_data, in_addr, in_sbit_err, in_dbit_err, out_ready,
    input  in_ready, out_valid, out_data, out_sbit_err, out_dbit_err
  );
endinterface

// File: rtl/ecc_57_rd_err_mon.sv
// ecc_57_rd_err_mon
//   Read-side stage after the 57/7 SECDED decoder. Registers corrected words
//   through a 2-entry skid buffer and keeps error statistics.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     bus (slave)     in_* valid/ready input stream, out_* valid/ready output
//     cnt_clr         synchronous clear of counters, sticky bits, capture
//     sbit_cnt        saturating count of accepted sbit words
//     dbit_cnt        saturating count of accepted dbit words
//     err_sticky      {dbit seen, sbit seen}
//     first_err_*     address/type of first error since clear
//     err_irq         one-cycle pulse after each accepted errored word
//   Build option: ECC_57_RD_DBIT_DROP_EN - dbit words are accounted for but
//   not forwarded to out_*.
module ecc_57_rd_err_mon #(
  parameter int unsigned DATA_WIDTH = 57,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_57_rd_err_mon_if.slave    bus,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [1:0]            err_sticky,
  output logic                  first_err_vld,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  first_err_type,
  output logic                  err_irq
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t state, next_state;

  // Word as stored in the buffer: {dbit, sbit, data}
  logic [DATA_WIDTH+1:0] in_word, out_word_q, skid_q;
  logic                  in_ready_q;
  logic                  n_sbit, n_dbit;
  logic                  accept, transfer, buf_wr;
  logic                  load_out, load_out_from_skid, load_skid;

  // Both flags set means uncorrectable: report as dbit only.
  assign n_dbit  = bus.in_dbit_err;
  assign n_sbit  = bus.in_sbit_err & ~bus.in_dbit_err;
  assign in_word = {n_dbit, n_sbit, bus.in_data};

  assign accept   = bus.in_valid & in_ready_q;
  assign transfer = bus.out_valid & bus.out_ready;

`ifdef ECC_57_RD_DBIT_DROP_EN
  assign buf_wr = accept & ~n_dbit;
`else
  assign buf_wr = accept;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state != S_EMPTY);
  assign {bus.out_dbit_err, bus.out_sbit_err, bus.out_data} = out_word_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= next_state;
      // Registered from next_state so in_ready tracks the new state directly.
      in_ready_q <= (next_state != S_FULL);
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_EMPTY: if (buf_wr) next_state = S_ONE;
      S_ONE: begin
        if (buf_wr && !transfer)      next_state = S_FULL;
        else if (!buf_wr && transfer) next_state = S_EMPTY;
      end
      S_FULL: if (transfer) next_state = S_ONE;
      default: next_state = S_EMPTY;
    endcase
  end

  // Buffer load controls
  always_comb begin
    load_out           = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    unique case (state)
      S_EMPTY: load_out = buf_wr;
      S_ONE: begin
        load_out  = buf_wr & transfer;
        load_skid = buf_wr & ~transfer;
      end
      S_FULL: load_out_from_skid = transfer;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_word_q <= '0;
      skid_q     <= '0;
    end else begin
      if (load_out)                out_word_q <= in_word;
      else if (load_out_from_skid) out_word_q <= skid_q;
      if (load_skid)               skid_q     <= in_word;
    end
  end

  // Error statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbit_cnt       <= '0;
      dbit_cnt       <= '0;
      err_sticky     <= '0;
      first_err_vld  <= 1'b0;
      first_err_addr <= '0;
      first_err_type <= 1'b0;
      err_irq        <= 1'b0;
    end else begin
      err_irq <= accept & (n_sbit | n_dbit);
      if (cnt_clr) begin
        sbit_cnt       <= '0;
        dbit_cnt       <= '0;
        err_sticky     <= '0;
        first_err_vld  <= 1'b0;
        first_err_addr <= '0;
        first_err_type <= 1'b0;
      end else if (accept) begin
        if (n_sbit) begin
          err_sticky[0] <= 1'b1;
          if (sbit_cnt != '1) sbit_cnt <= sbit_cnt + 1'b1;
        end
        if (n_dbit) begin
          err_sticky[1] <= 1'b1;
          if (dbit_cnt != '1) dbit_cnt <= dbit_cnt + 1'b1;
        end
        if ((n_sbit || n_dbit) && !first_err_vld) begin
          first_err_vld  <= 1'b1;
          first_err_addr <= bus.in_addr;
          first_err_type <= n_dbit;
        end
      end
    end
  end

endmodule

// File: tb/tb_ecc_57_rd_err_mon.sv
module tb_ecc_57_rd_err_mon;
  localparam int unsigned DW = 57;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cnt_clr;
  logic [CW-1:0] sbit_cnt, dbit_cnt;
  logic [1:0]    err_sticky;
  logic          first_err_vld;
  logic [AW-1:0] first_err_addr;
  logic          first_err_type;
  logic          err_irq;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  ecc_57_rd_err_mon_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ecc_57_rd_err_mon #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .cnt_clr        (cnt_clr),
    .sbit_cnt       (sbit_cnt),
    .dbit_cnt       (dbit_cnt),
    .err_sticky     (err_sticky),
    .first_err_vld  (first_err_vld),
    .first_err_addr (first_err_addr),
    .first_err_type (first_err_type),
    .err_irq        (err_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge; sample/drive 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] a,
                       input logic s, input logic db);
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.in_addr     = a;
    bus.in_sbit_err = s;
    bus.in_dbit_err = db;
  endtask

  initial begin
    rst = 1'b1;
    cnt_clr = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    tick(); tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sbit_cnt", sbit_cnt, 0);
    chk("rst_irq", err_irq, 0);
    rst = 1'b0;
    tick();
    chk("rel_in_ready", bus.in_ready, 1);

    // Clean words, consumer always ready: one-cycle latency, in order.
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DW'(i), '0, 1'b0, 1'b0);
      tick();
      chk("clean_valid", bus.out_valid, 1);
      chk("clean_data", bus.out_data, 64'(i));
      chk("clean_irq", err_irq, 0);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    chk("clean_drain", bus.out_valid, 0);
    chk("clean_sbit_cnt", sbit_cnt, 0);
    chk("clean_dbit_cnt", dbit_cnt, 0);

    // Backpressure: two accepted, third stalls, then drain in order.
    bus.out_ready = 1'b0;
    drive(1'b1, 57'h11, '0, 1'b0, 1'b0);
    tick();
    chk("bp_rdy_one", bus.in_ready, 1);
    drive(1'b1, 57'h12, '0, 1'b0, 1'b0);
    tick();
    chk("bp_rdy_full", bus.in_ready, 0);
    chk("bp_data0", bus.out_data, 64'h11);
    drive(1'b1, 57'h13, '0, 1'b0, 1'b0);
    tick();
    chk("bp_stall_rdy", bus.in_ready, 0);
    chk("bp_stable", bus.out_data, 64'h11);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_data1", bus.out_data, 64'h12);
    chk("bp_rdy_back", bus.in_ready, 1);
    tick();
    chk("bp_data2", bus.out_data, 64'h13);
    chk("bp_valid2", bus.out_valid, 1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    chk("bp_empty", bus.out_valid, 0);

    // Error accounting: 3 sbit then 1 dbit.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(64'h100 + i), AW'(8'h10 + i), 1'b1, 1'b0);
      tick();
      chk("sb_irq", err_irq, 1);
      chk("sb_flag", bus.out_sbit_err, 1);
      chk("sb_cnt", sbit_cnt, 64'(i + 1));
    end
    drive(1'b1, 57'h200, 8'h20, 1'b0, 1'b1);
    tick();
    chk("db_irq", err_irq, 1);
    chk("db_cnt", dbit_cnt, 1);
    chk("db_sbit_cnt", sbit_cnt, 3);
    chk("db_sticky", err_sticky, 2'b11);
    chk("db_first_vld", first_err_vld, 1);
    chk("db_first_addr", first_err_addr, 8'h10);
    chk("db_first_type", first_err_type, 0);
`ifdef ECC_57_RD_DBIT_DROP_EN
    chk("db_dropped", bus.out_valid, 0);
`else
    chk("db_out_flag", bus.out_dbit_err, 1);
    chk("db_out_data", bus.out_data, 64'h200);
`endif
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    chk("db_irq_end", err_irq, 0);

    // Clear, then saturation at 2^CW-1.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_sbit", sbit_cnt, 0);
    chk("clr_dbit", dbit_cnt, 0);
    chk("clr_sticky", err_sticky, 0);
    chk("clr_first", first_err_vld, 0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, DW'(i), AW'(8'h40 + i), 1'b1, 1'b0);
      tick();
      chk("sat_cnt", sbit_cnt, (i > 3) ? 64'd3 : 64'(i));
    end
    chk("sat_first_addr", first_err_addr, 8'h41);
    cnt_clr = 1'b1;
    drive(1'b1, 57'h6, 8'h46, 1'b1, 1'b0);
    tick();
    chk("clracc_cnt", sbit_cnt, 0);
    chk("clracc_first", first_err_vld, 0);
    chk("clracc_irq", err_irq, 1);
    chk("clracc_sticky", err_sticky, 0);
    cnt_clr = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    chk("clracc_irq_end", err_irq, 0);
    chk("clracc_cnt_hold", sbit_cnt, 0);

    // Both flags set: normalised to dbit.
    drive(1'b1, 57'h333, 8'h33, 1'b1, 1'b1);
    tick();
    chk("both_dbit_cnt", dbit_cnt, 1);
    chk("both_sbit_cnt", sbit_cnt, 0);
    chk("both_first_type", first_err_type, 1);
    chk("both_first_addr", first_err_addr, 8'h33);
    chk("both_sticky", err_sticky, 2'b10);
`ifdef ECC_57_RD_DBIT_DROP_EN
    chk("both_dropped", bus.out_valid, 0);
`else
    chk("both_valid", bus.out_valid, 1);
    chk("both_out_sbit", bus.out_sbit_err, 0);
    chk("both_out_dbit", bus.out_dbit_err, 1);
`endif
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();

    // Reset while FULL: asynchronous discard.
    bus.out_ready = 1'b0;
    drive(1'b1, 57'h501, '0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 57'h502, '0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("full_rdy", bus.in_ready, 0);
    chk("full_valid", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_dbit_cnt", dbit_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_valid", bus.out_valid, 0);
    chk("post_dbit_cnt", dbit_cnt, 0);
    chk("post_rdy", bus.in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
